// File: rtl/io_controller.sv
// io_controller: memory-mapped I/O decode in front of data memory, with an RX FIFO,
// an interval timer and a one-cycle exception request that is held while the CPU stalls.
module io_controller #(
  parameter int N = 8,
  parameter logic [N-1:0] IOBASE = 8'hF0,
  parameter int RXDEPTH = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] A,
  input  logic [N-1:0] WD,
  input  logic         WE,
  input  logic         RE,
  input  logic         BUSY,
  output logic [N-1:0] RD,
  output logic         ram_we,
  input  logic [N-1:0] ram_rd,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         IOException
);
  localparam int PW = $clog2(RXDEPTH);
  localparam logic [3:0] FULL_CNT = 4'(RXDEPTH);
  logic [7:0] mem [RXDEPTH];
  logic [PW-1:0] wp, rp;
  logic [3:0] cnt, ctrl;
  logic [N-1:0] reload, count, off, io_rdata;
  logic overflow, expired, irq_q, pend;
  logic io_sel, io_we, wr_ctrl, wr_reload, wr_clr;
  logic nonempty, full, push, pop, tmr_zero, irq_lvl;
  assign io_sel = A >= IOBASE;
  assign off = A - IOBASE;
  assign io_we = WE & io_sel & ~BUSY;
  assign wr_ctrl = io_we & (off == N'(2));
  assign wr_reload = io_we & (off == N'(3));
  assign wr_clr = io_we & (off == N'(4));
  assign nonempty = cnt != 4'd0;
  assign full = cnt == FULL_CNT;
  assign pop = RE & ~BUSY & (A == IOBASE + N'(1)) & nonempty;
  assign push = rx_valid & ~full;
  assign tmr_zero = ctrl[2] & (count == '0);
  assign irq_lvl = (ctrl[0] & (nonempty | overflow)) | (ctrl[1] & expired);
  assign IOException = pend & ~BUSY;
  assign ram_we = WE & ~io_sel;
  assign RD = io_sel ? io_rdata : ram_rd;
  always_comb
    io_rdata = off == N'(0) ? N'({cnt, expired, overflow, full, nonempty}) :
               off == N'(1) ? (nonempty ? N'(mem[rp]) : '0) :
               off == N'(2) ? N'(ctrl) :
               off == N'(3) ? reload :
               off == N'(5) ? count : '0;
  // FIFO storage needs no reset; emptiness is tracked by cnt
  always_ff @(posedge CLK)
    if (push) mem[wp] <= rx_data;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ctrl <= '0;
      reload <= '0;
      count <= '0;
      overflow <= 1'b0;
      expired <= 1'b0;
      irq_q <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + 4'(push) - 4'(pop);
      overflow <= (rx_valid & full) | (overflow & ~(wr_clr & WD[2]));
      expired <= tmr_zero | (expired & ~(wr_clr & WD[3]));
      if (wr_ctrl) ctrl <= WD[3:0];
      else if (tmr_zero & ~ctrl[3]) ctrl[2] <= 1'b0;
      if (wr_reload) reload <= WD;
      if (wr_reload) count <= WD;
      else if (ctrl[2]) count <= (count == '0) ? (ctrl[3] ? reload : '0) : count - 1'b1;
      irq_q <= irq_lvl;
      pend <= (irq_lvl & ~irq_q) | (pend & ~IOException);
    end
endmodule

// File: doc/io_controller.md
# io_controller

Memory-mapped I/O controller sitting directly downstream of the processor's data-memory port (A/WD/WE/RD). Decodes the bus address: RAM addresses pass straight through to data memory; the top of the address space maps a receive FIFO, an interval timer and control/status registers. Generates the single-cycle `IOException` request the processor consumes, held off while the processor is stalled.

## Interface
Parameters:
- `N`, 8: data and address width.
- `IOBASE`, 8'hF0: first I/O address; addresses `>= IOBASE` are I/O, all others are RAM.
- `RXDEPTH`, 8: receive FIFO depth; must be a power of two, `<= 15`.

Ports:
- `CLK`  in  1  clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `A`  in  N  processor bus address.
- `WD`  in  N  processor write data.
- `WE`  in  1  processor write strobe.
- `RE`  in  1  processor read strobe, driven from the load decode.
- `BUSY`  in  1  processor stall (cache busy); high means the current bus cycle repeats.
- `RD`  out  N  read data to the processor.
- `ram_we`  out  1  `WE & ~io_sel`.
- `ram_rd`  in  N  RAM read data.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `IOException`  out  1  exception request to the processor.

## Operation
- `io_sel = (A >= IOBASE)`. `RD = io_sel ? io_rdata : ram_rd`, combinational.
- Register map, as offsets from IOBASE:
  - +0 STATUS (RO): [0] rx_nonempty, [1] rx_full, [2] overflow (sticky), [3] expired (sticky), [7:4] rx count.
  - +1 RXDATA (RO): FIFO head; 0 when empty.
  - +2 CTRL (RW): [0] rx_irq_en, [1] tmr_irq_en, [2] tmr_en, [3] autoreload; [7:4] read 0.
  - +3 RELOAD (RW).
  - +4 IRQCLR (WO, reads 0): writing 1 to [2] clears overflow; writing 1 to [3] clears expired.
  - +5 COUNT (RO).
  - Other I/O offsets read 0 and ignore writes.
- FIFO pop: `RE & ~BUSY & A==IOBASE+1 & nonempty`. Reads with BUSY high never pop.
- FIFO push: `rx_valid & ~full`. If `rx_valid` arrives while full, the byte is dropped and overflow is set.
  - Simultaneous push and pop when full: the pop is taken, the push is dropped, and overflow is set (full is sampled before the edge).
  - Simultaneous push and pop otherwise: count is unchanged and order is preserved.
  - Pointers wrap modulo RXDEPTH.
- Timer, while tmr_en=1:
  - COUNT decrements by 1 per cycle.
  - When COUNT==0: expired is set. With autoreload=1, COUNT←RELOAD; with autoreload=0, tmr_en is cleared by hardware.
  - A write to RELOAD also loads COUNT with WD the same edge, overriding any decrement.
  - A CTRL write takes priority over the hardware clear of tmr_en.
- Sticky-flag priority: a set condition and an IRQCLR write in the same cycle leave the flag set.
- Interrupt:
  - `irq_lvl = rx_irq_en & (nonempty | overflow) | tmr_irq_en & expired`.
  - A rising edge of irq_lvl (against a registered copy of it) sets `pend`.
  - `IOException = pend & ~BUSY`, combinational.
  - pend clears at the edge where IOException=1, so the request is exactly one non-stalled cycle per edge.
  - irq_lvl staying high does not retrigger; it must fall and rise again.

## Timing
- Reset (asynchronous): FIFO empty, pointers 0, CTRL=0, RELOAD=0, COUNT=0, overflow=0, expired=0, pend=0, irq_lvl copy=0. Outputs during reset: `IOException`=0; `RD` and `ram_we` follow their combinational equations.
- Register writes take effect at the edge in which `WE & io_sel` is high, and are visible on `RD` the next cycle. I/O writes are gated by `~BUSY`.
- Push latency: a byte strobed at edge k is readable from RXDATA and counted in STATUS in cycle k+1.
- RELOAD=R, tmr_en set at edge k: COUNT reaches 0 in cycle k+R and expired is visible at k+R+1. With autoreload, the period is R+1 cycles.
- Interrupt latency: irq_lvl rising in cycle k gives `IOException` in cycle k+1 if BUSY=0 then; otherwise it is held until the first cycle with BUSY=0.
- Reset mid-operation: all state clears immediately; a pending exception is lost.

## Test plan
- RAM pass-through: A=8'h10, WE=1 → ram_we=1. A=8'hF2, WE=1 → ram_we=0 and CTRL=WD. RD returns ram_rd for A<8'hF0.
- FIFO: push 8 bytes 8'h01..8'h08 → STATUS=8'h83. A 9th push → overflow, STATUS=8'h87. Eight popping reads return 8'h01..8'h08 in order, then STATUS=8'h04.
- Push and pop in the same cycle with count=3 → count stays 3 and order is preserved. Same event when full → overflow set.
- Timer: RELOAD=3, CTRL=8'h0E → expired at the 4th cycle, then every 4 cycles. With autoreload=0 → single expiry, then CTRL[2]=0.
- Interrupt: CTRL=8'h01, push one byte → IOException high for exactly 1 cycle. With BUSY held high 5 cycles → the pulse is delayed to the first BUSY=0 cycle. A second push with FIFO still nonempty → no new pulse.
- Assert RESET mid-FIFO-fill and during pend → all registers read 0 and IOException=0 next cycle.
